// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC, FSM encoding and queue-entry layout for the fetch front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue2.sv
// fetch_queue2: 2-entry FIFO of {pc, instr} with synchronous flush.
// Latency: a word pushed in cycle N is at the head from cycle N+1.
// Backpressure: pop on empty and push on full (without a same-cycle pop) are ignored.
// Ports: clk/rst (async active-low), flush, push/push_dat, pop, head_vld/head_dat, count.
module fetch_queue2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  output logic         head_vld,
  output fetch_entry_t head_dat,
  output logic [1:0]   count
);

  fetch_entry_t ent0_q, ent1_q;
  logic [1:0]   count_q;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop & (count_q != 2'd0);
  assign push_ok = push & ((count_q != 2'd2) | pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= push_dat;
          else                 ent1_q <= push_dat;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: head leaves, new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            ent0_q <= push_dat;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_vld = (count_q != 2'd0);
  assign head_dat = ent0_q;
  assign count    = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC generator and fetch front-end presenting {instr, pc} to decode.
// Latency: word requested in cycle R is presented from cycle R+2; one word per cycle sustained.
// Backpressure: out_ready low holds the head stable; issue stops once queued + in-flight words reach 2.
// Ports: clk/rst (async active-low); imem_en/imem_addr/imem_rdata to the 1-cycle instruction memory;
//   redirect_valid/redirect_target from branch resolution; out_valid/out_ready/out_instr/out_pc to
//   decode; misalign_err is a sticky flag raised by a misaligned redirect target.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                IMEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               misalign_err
);

  generate
    if (IMEM_LAT != 1) begin : g_lat_check
      $error("fetch_sequencer: only IMEM_LAT=1 is supported");
    end
  endgenerate

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, inflight_pc_q;
  logic              inflight_q, misalign_q;
  logic [1:0]        q_count;
  logic              q_vld, pop, push, flush, issue, target_ok, take_redirect;
  fetch_entry_t      push_dat, head;

  assign pop       = q_vld & out_ready;
  assign target_ok = (redirect_target[1:0] == 2'b00);

  always_comb begin
    state_d       = state_q;
    flush         = 1'b0;
    issue         = 1'b0;
    take_redirect = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (target_ok) take_redirect = 1'b1;
          else           state_d       = HALT;
        end else if (({1'b0, q_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop})) begin
          // Gated by rst so no request is shown while reset is held.
          issue = rst;
        end
      end
      HALT:    ;
      default: ;
    endcase
  end

  // A redirect kills the word returning this cycle; nothing new was issued alongside it.
  assign push     = inflight_q & ~flush;
  assign push_dat = '{pc: inflight_pc_q, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
      if (take_redirect)  fetch_pc_q <= redirect_target;
      else if (issue)     fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
      if (state_d == HALT) misalign_q <= 1'b1;
    end
  end

  fetch_queue2 u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_vld (q_vld),
    .head_dat (head),
    .count    (q_count)
  );

  assign imem_en      = issue;
  assign imem_addr    = fetch_pc_q;
  assign out_valid    = q_vld;
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.RESET_PC(RST_PC), .IMEM_LAT(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .misalign_err    (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: word i holds 0x100 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  initial imem_rdata = 32'h0;
  always @(posedge clk) if (imem_en === 1'b1) imem_rdata <= mem_word(imem_addr);

  // Reference model: every request not yet consumed (queued or in flight), with the
  // cycle it was issued in; it becomes visible two cycles later.
  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } req_t;

  req_t        m_q[$];
  logic [31:0] m_pc   = RST_PC;
  logic        m_halt = 1'b0;
  logic        m_mis  = 1'b0;
  int          m_cyc  = 0;

  logic        obs_vld;
  logic [31:0] obs_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  // One clock cycle: inputs driven at negedge, outputs checked 1ns later, model advanced.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] tgt, input logic rdy);
    logic exp_vld, pop, exp_en;
    @(negedge clk);
    rst = r;
    redirect_valid = rv;
    redirect_target = tgt;
    out_ready = rdy;
    if (!r) begin
      m_q.delete();
      m_pc = RST_PC;
      m_halt = 1'b0;
      m_mis = 1'b0;
    end
    #1;
    exp_vld = r && !m_halt && (m_q.size() > 0) && (m_q[0].cyc + 2 <= m_cyc);
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
    if (exp_vld) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_instr", out_instr, mem_word(m_q[0].pc));
    end
    pop = exp_vld && rdy;
    exp_en = r && !m_halt && !rv && ((m_q.size() - int'(pop)) < 2);
    check("imem_en", {31'b0, imem_en}, {31'b0, exp_en});
    if (exp_en) check("imem_addr", imem_addr, m_pc);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    obs_vld = out_valid;
    obs_pc = out_pc;
    if (!r) begin
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_imem_addr", imem_addr, RST_PC);
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rv && !m_halt) begin
        m_q.delete();
        if (tgt[1:0] == 2'b00) m_pc = tgt;
        else begin
          m_halt = 1'b1;
          m_mis = 1'b1;
        end
      end else if (exp_en) begin
        m_q.push_back('{pc: m_pc, cyc: m_cyc});
        m_pc = m_pc + 32'd4;
      end
    end
    m_cyc++;
  endtask

  // Run with out_ready=1 until a word is presented; its pc must be exp_pc.
  task automatic expect_next(input string tag, input logic [31:0] exp_pc);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      seen = obs_vld;
    end
    check({tag, "_seen"}, {31'b0, seen}, 32'h1);
    if (seen) check(tag, obs_pc, exp_pc);
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    out_ready = 1'b0;

    // Reset state held for a few cycles.
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Release: request in cycle 1, first word visible in cycle 3, then one per cycle.
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check("first_word_not_yet", {31'b0, obs_vld}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("first_word_cycle3", {31'b0, obs_vld}, 32'h1);
    check("first_word_pc", obs_pc, 32'h0);

    // Backpressure for 5 cycles, then resume.
    repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect to 0x40 while the queue is full.
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h40, 1'b0);
    expect_next("redir40_pc", 32'h40);

    // Redirect to 0x80 in the same cycle as an accepted pop.
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h80, 1'b1);
    expect_next("redir80_pc", 32'h80);

    // Randomized traffic with occasional aligned redirects.
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      t[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + {28'h0, t[3:2], 2'b00};
      cycle(1'b1, ($urandom_range(0, 15) == 0), t, ($urandom_range(0, 3) != 0));
    end

    // Wrap-around of the fetch address.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    expect_next("wrap_pc0", 32'hFFFF_FFF8);
    expect_next("wrap_pc1", 32'hFFFF_FFFC);
    expect_next("wrap_pc2", 32'h0000_0000);
    expect_next("wrap_pc3", 32'h0000_0004);

    // Reset asserted mid-stream with words queued, then restart from RESET_PC.
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    expect_next("restart_pc", RST_PC);
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Misaligned redirect: sticky error, halted, later redirects ignored.
    cycle(1'b1, 1'b1, 32'h42, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check("misalign_next", {31'b0, misalign_err}, 32'h1);
    repeat (20) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    expect_next("recover_pc", RST_PC);
    repeat (40) cycle(1'b1, 1'b0, 32'h0, ($urandom_range(0, 1) != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
